hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Drives ControlUnit's Pipe_stall input and all pipeline-register hold/flush enables.

---
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard, branch-flush, I/O-freeze and halt sequencer
module hazard_stall_ctrl #(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int IO_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic        id_undef,
    input  logic        ex_memr,
    input  logic [4:0]  ex_rt,
    input  logic        ex_br_taken,
    input  logic        mem_io,
    input  logic        io_ack,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_stall,
    output logic        freeze_all,
    output logic        io_req,
    output logic        io_err,
    output logic        halted,
    output logic [15:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, IO_WAIT, BR_FLUSH, HALT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  io_cnt, io_cnt_nxt;
    logic [1:0]  br_cnt, br_cnt_nxt;
    logic [15:0] stall_cnt;

    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       rs_used, rt_used, load_use, run_path;
    logic       pc_hold_c, ifid_hold_c, ifid_flush_c, idex_flush_c;
    logic       pipe_stall_c, freeze_all_c, io_req_c, io_err_c, halted_c;
    logic       unused_inst;

    assign op = id_inst[31:26];
    assign rs = id_inst[25:21];
    assign rt = id_inst[20:16];
    assign unused_inst = ^id_inst[15:0];

    assign rs_used  = !(op == 6'b000010 || op == 6'b000011);
    assign rt_used  = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
                      (op == 6'b101011) || (op == 6'b101100);
    assign load_use = ex_memr && (ex_rt != 5'd0) &&
                      ((rs_used && rs == ex_rt) || (rt_used && rt == ex_rt));

    // A pending I/O op in MEM cuts a branch flush short and is handled exactly as from RUN.
    assign run_path = (state == RUN) || (state == BR_FLUSH && mem_io);

    always_comb begin
        state_nxt    = state;
        io_cnt_nxt   = io_cnt;
        br_cnt_nxt   = br_cnt;
        pc_hold_c    = 1'b0;
        ifid_hold_c  = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        pipe_stall_c = 1'b0;
        freeze_all_c = 1'b0;
        io_req_c     = 1'b0;
        io_err_c     = 1'b0;
        halted_c     = 1'b0;

        if (run_path) begin
            state_nxt = RUN;
            if (mem_io && !io_ack) begin
                io_req_c     = 1'b1;
                freeze_all_c = 1'b1;
                pc_hold_c    = 1'b1;
                ifid_hold_c  = 1'b1;
                state_nxt    = IO_WAIT;
                io_cnt_nxt   = 8'd0;
            end else begin
                io_req_c = mem_io;
                if (ex_br_taken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_nxt  = BR_FLUSH;
                        br_cnt_nxt = 2'(BR_FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    pipe_stall_c = 1'b1;
                end else if (id_undef) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    pipe_stall_c = 1'b1;
                    state_nxt    = HALT;
                end
            end
        end else begin
            case (state)
                IO_WAIT: begin
                    io_req_c     = 1'b1;
                    freeze_all_c = 1'b1;
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    io_cnt_nxt   = io_cnt + 8'd1;
                    if (io_ack) begin
                        state_nxt = RUN;
                    end else if (io_cnt == 8'(IO_TIMEOUT - 1)) begin
                        io_err_c  = 1'b1;
                        state_nxt = RUN;
                    end
                end
                BR_FLUSH: begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    br_cnt_nxt   = br_cnt - 2'd1;
                    if (br_cnt <= 2'd1) begin
                        state_nxt = RUN;
                    end
                end
                HALT: begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    pipe_stall_c = 1'b1;
                    halted_c     = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign pc_hold      = !rst && pc_hold_c;
    assign ifid_hold    = !rst && ifid_hold_c;
    assign ifid_flush   = !rst && ifid_flush_c;
    assign idex_flush   = !rst && idex_flush_c;
    assign pipe_stall   = !rst && pipe_stall_c;
    assign freeze_all   = !rst && freeze_all_c;
    assign io_req       = !rst && io_req_c;
    assign io_err       = !rst && io_err_c;
    assign halted       = !rst && halted_c;
    assign stall_cycles = rst ? 16'd0 : stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            io_cnt    <= 8'd0;
            br_cnt    <= 2'd0;
            stall_cnt <= 16'd0;
        end else begin
            state  <= state_nxt;
            io_cnt <= io_cnt_nxt;
            br_cnt <= br_cnt_nxt;
            if (pc_hold_c && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    localparam int BR = 3;
    localparam int TO = 8;

    typedef struct {
        logic [8:0]  flags;
        logic [15:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_inst = 32'd0;
    logic        id_undef = 1'b0;
    logic        ex_memr = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic        ex_br_taken = 1'b0;
    logic        mem_io = 1'b0;
    logic        io_ack = 1'b0;
    logic        pc_hold, ifid_hold, ifid_flush, idex_flush, pipe_stall;
    logic        freeze_all, io_req, io_err, halted;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    bit m_halt = 0;
    bit m_io = 0;
    int m_io_el = 0;
    int m_fl = 0;
    int m_st = 0;

    hazard_stall_ctrl #(.BR_FLUSH_CYCLES(BR), .IO_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_undef(id_undef),
        .ex_memr(ex_memr), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
        .mem_io(mem_io), .io_ack(io_ack), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_stall(pipe_stall),
        .freeze_all(freeze_all), .io_req(io_req), .io_err(io_err), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit ref_load_use(logic [31:0] inst, bit memr, logic [4:0] xrt);
        int o = int'(inst[31:26]);
        bit rs_src = (o != 2) && (o != 3);
        bit rt_src = (o == 0) || (o == 4) || (o == 5) || (o == 43) || (o == 44);
        return memr && (xrt != 0) &&
               ((rs_src && inst[25:21] == xrt) || (rt_src && inst[20:16] == xrt));
    endfunction

    task automatic drive(input bit r, input logic [31:0] inst, input bit undef, input bit memr,
                         input logic [4:0] xrt, input bit br, input bit mio, input bit ack);
        exp_t e;
        bit pc = 0, ih = 0, ff = 0, xf = 0, ps = 0, fz = 0, rq = 0, er = 0, hl = 0;
        bit lu;
        @(posedge clk);
        #1;
        rst = r; id_inst = inst; id_undef = undef; ex_memr = memr; ex_rt = xrt;
        ex_br_taken = br; mem_io = mio; io_ack = ack;
        lu = ref_load_use(inst, memr, xrt);
        e.stall = r ? 16'd0 : 16'(m_st);
        if (r) begin
            m_halt = 0; m_io = 0; m_io_el = 0; m_fl = 0; m_st = 0;
        end else begin
            if (m_halt) begin
                pc = 1; ih = 1; ps = 1; hl = 1;
            end else if (m_io) begin
                pc = 1; ih = 1; fz = 1; rq = 1;
                if (ack) m_io = 0;
                else if (m_io_el == TO - 1) begin er = 1; m_io = 0; end
                else m_io_el++;
            end else if (m_fl > 0 && !mio) begin
                ff = 1; xf = 1; m_fl--;
            end else begin
                m_fl = 0;
                if (mio && !ack) begin
                    pc = 1; ih = 1; fz = 1; rq = 1; m_io = 1; m_io_el = 0;
                end else begin
                    rq = mio;
                    if (br) begin
                        ff = 1; xf = 1; m_fl = BR - 1;
                    end else if (lu) begin
                        pc = 1; ih = 1; ps = 1;
                    end else if (undef) begin
                        pc = 1; ih = 1; ps = 1; m_halt = 1;
                    end
                end
            end
            if (pc && m_st < 65535) m_st++;
        end
        e.flags = {pc, ih, ff, xf, ps, fz, rq, er, hl};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 32'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic rand_cycle(input bit allow_rst, input bit allow_undef);
        logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h2c, 6'h24, 6'h08};
        logic [31:0] inst;
        inst = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        drive(allow_rst && ($urandom_range(0, 79) == 0), inst,
              allow_undef && ($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e = exp_q.pop_front();
            act = {pc_hold, ifid_hold, ifid_flush, idex_flush, pipe_stall, freeze_all, io_req, io_err, halted};
            checks++;
            if (act !== e.flags) begin
                errors++;
                $display("FAIL flags t=%0t actual=%b expected=%b", $time, act, e.flags);
            end
            checks++;
            if (stall_cycles !== e.stall) begin
                errors++;
                $display("FAIL stall_cycles t=%0t actual=%h expected=%h", $time, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        logic [31:0] add_i, sw_i, j_i;
        add_i = {6'd0, 5'd5, 5'd2, 5'd3, 11'h020};
        sw_i  = {6'h2b, 5'd1, 5'd5, 16'd0};
        j_i   = {6'h02, 5'd5, 5'd5, 16'd0};

        drive(1, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        drive(1, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        idle(2);
        // load-use cases
        drive(0, add_i, 0, 1, 5'd5, 0, 0, 0); idle(1);
        drive(0, add_i, 0, 1, 5'd0, 0, 0, 0); idle(1);
        drive(0, sw_i, 0, 1, 5'd5, 0, 0, 0);  idle(1);
        drive(0, j_i, 0, 1, 5'd5, 0, 0, 0);   idle(1);
        // branch flush with a simultaneous load-use
        drive(0, add_i, 0, 1, 5'd5, 1, 0, 0); idle(4);
        // I/O acked after four frozen cycles
        for (int i = 0; i < 4; i++) drive(0, 32'd0, 0, 0, 5'd0, 0, 1, 0);
        drive(0, 32'd0, 0, 0, 5'd0, 0, 1, 1);
        idle(2);
        // I/O timeout
        for (int i = 0; i < TO + 2; i++) drive(0, 32'd0, 0, 0, 5'd0, 0, 1, 0);
        idle(2);
        // reset during IO_WAIT
        drive(0, 32'd0, 0, 0, 5'd0, 0, 1, 0);
        drive(0, 32'd0, 0, 0, 5'd0, 0, 1, 0);
        drive(1, 32'd0, 0, 0, 5'd0, 0, 1, 0);
        for (int i = 0; i < TO + 2; i++) drive(0, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        // randomized mix
        for (int i = 0; i < 4000; i++) rand_cycle(1, 1);
        // halt, then run long enough to saturate the stall counter
        drive(1, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        drive(0, 32'd0, 1, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 65600; i++) rand_cycle(0, 1);
        drive(1, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
